pcrel_exec_pipe: RTL
====================

# pcrel_exec_pipe

Pipelined, parametrised successor to the combinational U-type execute unit. Computes LUI, AUIPC, link-address (PC+4) and PC-relative target results, then carries each result with its destination tag through a configurable number of valid/ready register stages. It sits in the execute stage next to the main ALU and feeds the EX/MEM boundary. It supports back-pressure stalls and a pipeline flush on branch mispredict.

## Interface
Parameters:
- XLEN, 32: datapath width for pc, imm and result.
- STAGES, 2: number of register stages, legal range 1..4.
- RD_W, 5: destination-register tag width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  request present.
- in_ready  output  1  unit accepts the request this cycle.
- pc  input  XLEN  program counter of the instruction.
- imm_u  input  XLEN  immediate, already shifted or sign-extended by decode.
- aluSelect  input  6  operation select, one-hot (see Operation).
- rd_in  input  RD_W  destination tag.
- flush  input  1  synchronous kill of all in-flight entries.
- out_valid  output  1  result present at the last stage.
- out_ready  input  1  downstream accepts the result.
- result  output  XLEN  computed value.
- rd_out  output  RD_W  tag travelling with the result.
- illegal  output  1  the entry's aluSelect was not a supported code.

## Operation
- Op decode on aluSelect:
  - 6'b000001 LUI: result = imm_u.
  - 6'b000010 AUIPC: result = pc + imm_u.
  - 6'b000100 LINK: result = pc + 4.
  - 6'b001000 TARGET: result = pc + imm_u, with bit 0 cleared.
  - Any other value: result = 0 and illegal = 1. The entry still flows and is not dropped.
- Arithmetic: unsigned, modulo 2^XLEN, and no overflow flag.
  - pc = 0xFFFF_FFFC with LINK gives 0x0000_0000.
  - pc = 0xFFFF_F000 and imm_u = 0x0000_2000 with AUIPC gives 0x0000_1000.
- Computation is combinational at the input and captured into stage 0. Later stages only forward {result, rd, illegal, valid}.
- Each stage has a valid bit v[i] and advances when !v[i] or when the next stage accepts. The last stage accepts when out_ready is high.
- Bubbles collapse: an empty stage accepts even when a downstream stage is stalled.
- in_ready = !flush && (!v[0] || stage 0 advances). It is combinational from out_ready.
- Handshake rules:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - While out_valid is high and out_ready is low, result, rd_out and illegal hold stable.
- flush:
  - On the edge where flush is high, every v[i] clears.
  - An in_valid presented in the flush cycle is not accepted, because in_ready is 0.
  - Data registers need not clear.
  - If flush and out_ready are both high in the same cycle, the entry at the output still counts as consumed.
- Reset (rst_n low, asynchronous): all v[i] = 0 and all data registers = 0. Consequently out_valid = 0, result = 0, rd_out = 0 and illegal = 0. in_ready reads 1 once rst_n is high.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Timing
- Latency: a request accepted at edge N appears on out_valid after edge N+STAGES-1. With STAGES=1 it is visible right after the accept edge.
- Throughput: one result per cycle while out_ready stays high.
- Full condition: all STAGES entries are valid and out_ready is low. in_ready is 0 in this state.
- Releasing a full pipe: one out_ready pulse frees one slot. in_ready rises in that same cycle.
- Simultaneous accept and drain when full: allowed, and occupancy stays constant.
- Ordering: results leave in strict acceptance order. No entry is duplicated or lost except through flush or reset.

## Test plan
- Basic ops, STAGES=2, out_ready=1:
  - pc=0x1000, imm=0x12345000, sel 000001 -> result 0x12345000 two cycles later.
  - sel 000010 -> 0x12346000.
  - sel 000100 -> 0x1004.
  - sel 001000 with imm=0x7 -> 0x1006.
- Wrap and illegal:
  - pc=0xFFFFFFFC, LINK -> 0x0.
  - sel 6'b100000 -> result 0 with illegal=1, and rd_out equal to rd_in.
- Back-pressure:
  - Stream 6 requests with rd 1..6 while holding out_ready=0.
  - After 2 accepts, in_ready must go 0 and result must stay 0-tag-1 stable.
  - Release out_ready -> rd_out sequence 1..6, one per cycle, with no gaps.
- Bubble collapse:
  - Request, idle cycle, request, with out_ready=0.
  - Both requests must be held in the pipe, and in_ready must be 0 after the second.
- Flush:
  - Fill 2 entries, then assert flush with in_valid=1 -> next cycle out_valid=0, and the flush-cycle request never emerges.
- Reset mid-stream:
  - Drop rst_n between edges while full -> out_valid, result and rd_out go 0 without a clock edge.
  - Repeat the basic-ops check with STAGES=1 and STAGES=4 for latency.

Source files
------------

// File: rtl/pcrel_exec_pipe.sv
// pcrel_exec_pipe: LUI/AUIPC/LINK/TARGET results carried with their dest tag through STAGES valid/ready registers.
// Latency: a request accepted at edge N shows on out_valid after edge N+STAGES-1 (STAGES legal range 1..4).
// Backpressure: a stage advances when empty or when downstream accepts; in_ready is combinational from out_ready.
module pcrel_exec_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int RD_W   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm_u,
  input  logic [5:0]      aluSelect,
  input  logic [RD_W-1:0] rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_out,
  output logic            illegal
);

  localparam logic [5:0] SEL_LUI    = 6'b000001;
  localparam logic [5:0] SEL_AUIPC  = 6'b000010;
  localparam logic [5:0] SEL_LINK   = 6'b000100;
  localparam logic [5:0] SEL_TARGET = 6'b001000;

  logic [XLEN-1:0] sum_pi;
  logic [XLEN-1:0] calc_res;
  logic            calc_ill;
  logic            accept;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] ill_q;
  logic [XLEN-1:0]   res_q [STAGES];
  logic [RD_W-1:0]   rd_q  [STAGES];

  assign sum_pi = pc + imm_u;

  // Operation decode; anything other than the four one-hot codes yields 0 and flags illegal.
  always_comb begin
    calc_res = '0;
    calc_ill = 1'b0;
    case (aluSelect)
      SEL_LUI:    calc_res = imm_u;
      SEL_AUIPC:  calc_res = sum_pi;
      SEL_LINK:   calc_res = pc + XLEN'(4);
      SEL_TARGET: calc_res = {sum_pi[XLEN-1:1], 1'b0};
      default:    calc_ill = 1'b1;
    endcase
  end

  // Advance chain from the output backwards: an empty stage always advances, so bubbles collapse.
  always_comb begin
    logic nxt;
    adv = '0;
    nxt = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = !v[i] || nxt;
      nxt    = adv[i];
    end
  end

  assign in_ready = !flush && adv[0];
  assign accept   = in_valid && in_ready;

  // Stage registers: stage 0 captures the decoded result, later stages forward; flush kills all valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v     <= '0;
      ill_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        res_q[i] <= '0;
        rd_q[i]  <= '0;
      end
    end else begin
      if (adv[0]) begin
        v[0] <= accept;
        if (accept) begin
          res_q[0] <= calc_res;
          rd_q[0]  <= rd_in;
          ill_q[0] <= calc_ill;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            res_q[i] <= res_q[i-1];
            rd_q[i]  <= rd_q[i-1];
            ill_q[i] <= ill_q[i-1];
          end
        end
      end
      if (flush) begin
        v <= '0;
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign result    = res_q[STAGES-1];
  assign rd_out    = rd_q[STAGES-1];
  assign illegal   = ill_q[STAGES-1];

endmodule
